// File: rtl/dlyc_tdc_pkg.sv
// Shared types and constants for the delay-chain TDC controller.
package dlyc_tdc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRE,
    ST_CAP1,
    ST_CAP2,
    ST_RECOV
  } state_e;

  localparam int RECOV_TIMEOUT = 8;

  // Width needed to hold a tap count in 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dlyc_therm_enc.sv
// Thermometer-to-count encoder: ones run from tap 0, plus bubble and all-ones flags.
module dlyc_therm_enc #(
  parameter int NTAPS = 16,
  parameter int CW    = 5
) (
  input  logic [NTAPS-1:0] therm_i,
  output logic [CW-1:0]    count_o,
  output logic             bubble_o,
  output logic             sat_o
);

  logic seen_zero;

  // Count stops at the first zero; any one found past it is a bubble.
  always_comb begin
    count_o   = '0;
    bubble_o  = 1'b0;
    seen_zero = 1'b0;
    for (int i = 0; i < NTAPS; i++) begin
      if (therm_i[i]) begin
        if (seen_zero) bubble_o = 1'b1;
        else           count_o  = count_o + CW'(1);
      end else begin
        seen_zero = 1'b1;
      end
    end
  end

  assign sat_o = &therm_i;

endmodule

// File: rtl/dlyc_chain_tdc.sv
// Launches edges into a dlyc chain, samples the taps one period later and
// averages 2^AVG_LOG2 thermometer counts into a delay-per-clock code.
module dlyc_chain_tdc
  import dlyc_tdc_pkg::*;
#(
  parameter int NTAPS    = 16,
  parameter int AVG_LOG2 = 2,
  parameter int CW       = cnt_w(NTAPS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  output logic             LAUNCH,
  input  logic [NTAPS-1:0] TAPS,
  output logic [CW-1:0]    CODE,
  output logic             VALID,
  output logic             BUSY,
  output logic             ERR,
  output logic             SAT
);

  localparam int AW = CW + AVG_LOG2;
  localparam int LW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int NL = 1 << AVG_LOG2;
  localparam int TW = $clog2(RECOV_TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [NTAPS-1:0] s1_q, s2_q;
  logic             launch_q, launch_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [LW-1:0]    lcnt_q, lcnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             err_s_q, err_s_d, sat_s_q, sat_s_d;
  logic [CW-1:0]    code_q, code_d;
  logic             valid_q, valid_d, busy_q, busy_d, err_q, err_d, sat_q, sat_d;

  logic [CW-1:0]    cnt;
  logic             bubble, all_ones;
  logic             drained, last, timeout;

  dlyc_therm_enc #(.NTAPS(NTAPS), .CW(CW)) u_enc (
    .therm_i  (s2_q),
    .count_o  (cnt),
    .bubble_o (bubble),
    .sat_o    (all_ones)
  );

  assign drained = (s2_q == '0);
  assign last    = (lcnt_q == LW'(NL - 1));
  assign timeout = !drained && (tmo_q == TW'(RECOV_TIMEOUT - 1));

  // Two-flop synchroniser runs freely so RECOV can watch the chain drain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= TAPS;
      s2_q <= s1_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (START) state_d = ST_FIRE;
      ST_FIRE:  state_d = ST_CAP1;
      ST_CAP1:  state_d = ST_CAP2;
      ST_CAP2:  state_d = ST_RECOV;
      ST_RECOV: begin
        if (drained)      state_d = last ? ST_IDLE : ST_FIRE;
        else if (timeout) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    launch_d = launch_q;
    acc_d    = acc_q;
    lcnt_d   = lcnt_q;
    tmo_d    = tmo_q;
    err_s_d  = err_s_q;
    sat_s_d  = sat_s_q;
    code_d   = code_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    err_d    = err_q;
    sat_d    = sat_q;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          launch_d = 1'b1;
          acc_d    = '0;
          lcnt_d   = '0;
          err_s_d  = 1'b0;
          sat_s_d  = 1'b0;
          busy_d   = 1'b1;
        end
      end
      ST_FIRE: launch_d = 1'b0;
      ST_CAP1: ;
      ST_CAP2: begin
        acc_d   = acc_q + AW'(cnt);
        err_s_d = err_s_q | bubble;
        sat_s_d = sat_s_q | all_ones;
        tmo_d   = '0;
      end
      ST_RECOV: begin
        if (drained) begin
          if (last) begin
            valid_d = 1'b1;
            busy_d  = 1'b0;
            code_d  = acc_q[AW-1:AVG_LOG2];
            err_d   = err_s_q;
            sat_d   = sat_s_q;
          end else begin
            launch_d = 1'b1;
            lcnt_d   = lcnt_q + LW'(1);
          end
        end else if (timeout) begin
          // Chain never drained: discard the average and flag the abort.
          valid_d = 1'b1;
          busy_d  = 1'b0;
          code_d  = '0;
          err_d   = 1'b1;
          sat_d   = sat_s_q;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      launch_q <= 1'b0;
      acc_q    <= '0;
      lcnt_q   <= '0;
      tmo_q    <= '0;
      err_s_q  <= 1'b0;
      sat_s_q  <= 1'b0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      launch_q <= launch_d;
      acc_q    <= acc_d;
      lcnt_q   <= lcnt_d;
      tmo_q    <= tmo_d;
      err_s_q  <= err_s_d;
      sat_s_q  <= sat_s_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      sat_q    <= sat_d;
    end
  end

  assign LAUNCH = launch_q;
  assign CODE   = code_q;
  assign VALID  = valid_q;
  assign BUSY   = busy_q;
  assign ERR    = err_q;
  assign SAT    = sat_q;

endmodule

// File: tb/tb_dlyc_chain_tdc.sv
// Directed bench: a behavioural delay chain answers LAUNCH with per-launch tap patterns.
module tb_dlyc_chain_tdc;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        launch;
  logic [15:0] taps;
  logic [4:0]  code;
  logic        valid, busy, err, sat;

  logic [3:0][15:0] cur_pats = '0;
  logic        stuck = 1'b0;
  int          nlaunch = 0;
  int          base = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  typedef struct {
    logic [3:0][15:0] pats;   // pats[k] is the chain response to launch k
    logic             stuck;  // taps held at 0x0001 regardless of LAUNCH
    logic [4:0]       code;
    logic             err;
    logic             sat;
    int               lat;
  } vec_t;

  vec_t vt[7];

  dlyc_chain_tdc dut (
    .CLK    (clk),
    .RST    (rst),
    .START  (start),
    .LAUNCH (launch),
    .TAPS   (taps),
    .CODE   (code),
    .VALID  (valid),
    .BUSY   (busy),
    .ERR    (err),
    .SAT    (sat)
  );

  always #5 clk = ~clk;

  always @(negedge launch) nlaunch = nlaunch + 1;

  always_comb begin
    logic [1:0] sel;
    sel  = 2'(nlaunch - base);
    taps = stuck ? 16'h0001 : (launch ? cur_pats[sel] : 16'h0000);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_meas(input vec_t v, input string nm);
    int n;
    bit seen;
    cur_pats = v.pats;
    stuck    = v.stuck;
    @(negedge clk);
    base  = nlaunch;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({nm, " busy_after_start"}, 32'(busy), 1);
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (valid) seen = 1;
    end
    chk({nm, " valid_seen"}, 32'(seen), 1);
    chk({nm, " latency"}, n, v.lat);
    chk({nm, " code"}, 32'(code), 32'(v.code));
    chk({nm, " err"}, 32'(err), 32'(v.err));
    chk({nm, " sat"}, 32'(sat), 32'(v.sat));
    chk({nm, " busy_at_valid"}, 32'(busy), 0);
    stuck = 1'b0;
  endtask

  initial begin
    int  n;
    bit  seen;

    vt[0] = '{pats: {4{16'h00FF}}, stuck: 0, code: 5'd8,  err: 0, sat: 0, lat: 16};
    vt[1] = '{pats: {16'h00FF, 16'h00FF, 16'h00FF, 16'h007F}, stuck: 0, code: 5'd7, err: 0, sat: 0, lat: 16};
    vt[2] = '{pats: {4{16'h0F3F}}, stuck: 0, code: 5'd6,  err: 1, sat: 0, lat: 16};
    vt[3] = '{pats: {4{16'hFFFF}}, stuck: 0, code: 5'd16, err: 0, sat: 1, lat: 16};
    vt[4] = '{pats: {4{16'h0000}}, stuck: 0, code: 5'd0,  err: 0, sat: 0, lat: 16};
    // 16+8+8+8 = 40 -> 10
    vt[5] = '{pats: {16'h00FF, 16'h00FF, 16'h00FF, 16'hFFFF}, stuck: 0, code: 5'd10, err: 0, sat: 1, lat: 16};
    // Drain never happens: 8 RECOV cycles after e0+3 end at edge e0+11
    vt[6] = '{pats: {4{16'h00FF}}, stuck: 1, code: 5'd0,  err: 1, sat: 0, lat: 11};

    rst   = 1'b1;
    start = 1'b0;
    #12;
    chk("reset launch", 32'(launch), 0);
    chk("reset valid",  32'(valid),  0);
    chk("reset busy",   32'(busy),   0);
    chk("reset err",    32'(err),    0);
    chk("reset sat",    32'(sat),    0);
    chk("reset code",   32'(code),   0);
    @(negedge clk);
    rst = 1'b0;

    // Consecutive runs also exercise back-to-back START acceptance
    for (int i = 0; i < 7; i++) run_meas(vt[i], $sformatf("vec%0d", i));

    // Reset while LAUNCH is high must drop it without a clock edge
    cur_pats = {4{16'h00FF}};
    @(negedge clk);
    base  = nlaunch;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("fire launch_high", 32'(launch), 1);
    #1 rst = 1'b1;
    #1;
    chk("fire rst launch_async", 32'(launch), 0);
    chk("fire rst busy_async", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset during CAP2 of launch 1 (edge e0+6), then confirm no VALID
    @(negedge clk);
    base  = nlaunch;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("cap2 rst launch", 32'(launch), 0);
    chk("cap2 rst busy", 32'(busy), 0);
    chk("cap2 rst valid", 32'(valid), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (n = 0; n < 30; n++) begin
      @(posedge clk);
      #1;
      if (valid || busy) seen = 1;
    end
    chk("cap2 rst no_valid", 32'(seen), 0);

    run_meas(vt[0], "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dlyc_chain_tdc.md
# dlyc_chain_tdc

Time-to-digital measurement controller that sits directly downstream of a chain of `dlyc` delay cells. It launches a rising edge into the head of the chain and samples every tap output one clock period later. It converts the resulting thermometer pattern to a tap count and averages 2^AVG_LOG2 launches. The output is a delay-per-clock code used for PVT characterisation and delay-line calibration.

## Interface
- `NTAPS`, 16: number of `dlyc` taps observed; tap 0 is nearest the launch point.
- `AVG_LOG2`, 2: log2 of the number of launches averaged per measurement.
- `CW`, $clog2(NTAPS+1): width of the count and `CODE`.
- `CLK`, in, 1: single clock; all state is on the rising edge.
- `RST`, in, 1: reset, asynchronous and active-high; clears all state and outputs.
- `START`, in, 1: request a measurement; sampled in IDLE only.
- `LAUNCH`, out, 1: registered drive into the `I` input of the first `dlyc`.
- `TAPS`, in, NTAPS: `Z` outputs of the chain, asynchronous to `CLK`.
- `CODE`, out, CW: averaged tap count, held until the next `VALID`.
- `VALID`, out, 1: one-cycle pulse when `CODE`, `ERR` and `SAT` update.
- `BUSY`, out, 1: high from START acceptance until the cycle in which `VALID` is high.
- `ERR`, out, 1: measurement had a bubble or a recovery timeout.
- `SAT`, out, 1: at least one launch saw all taps high.

## Operation
- States: IDLE, FIRE, CAP1, CAP2, RECOV.
- IDLE:
  - `START`=1 → FIRE, `LAUNCH`<=1, accumulator, launch counter and sticky flags cleared.
  - `START` while `BUSY` is ignored.
- FIRE → CAP1 unconditionally:
  - stage-1 capture register <= `TAPS`
  - `LAUNCH`<=0
- CAP1 → CAP2: stage-2 <= stage-1 (metastability filter).
- CAP2 → RECOV: the accumulator adds the count of stage-2.
- Count and flag rules:
  - count = number of consecutive ones from tap 0 (0..NTAPS).
  - bubble = any 1 above the first 0; sets sticky ERR.
  - count==NTAPS sets sticky SAT.
- RECOV:
  - Waits for stage-2 == 0, i.e. the chain has drained. Then it either goes to FIRE with `LAUNCH`<=1, or, after the last launch, goes to IDLE and asserts `VALID`.
  - A timeout counter runs while in RECOV. After 8 consecutive RECOV cycles with stage-2 != 0, the measurement aborts: → IDLE, `VALID`=1, `ERR`=1, `CODE`=0.
- Accumulator width is CW+AVG_LOG2; it cannot overflow.
- `CODE` = accumulator >> AVG_LOG2, truncated.
- Reset values: `LAUNCH`, `VALID`, `BUSY`, `ERR`, `SAT` = 0; `CODE` = 0; state IDLE; both capture stages 0.
- `RST` mid-measurement aborts immediately: `LAUNCH` drops asynchronously and no `VALID` is issued.

## Timing
- Take `START` sampled at edge e0. Launch k (0-based) asserts `LAUNCH` after edge e0+4k. Taps are captured at e0+4k+1 and accumulated at e0+4k+3. RECOV exits at e0+4k+4 when the chain drains within one period.
- Nominal latency: `VALID` high in the cycle after edge e0+4·2^AVG_LOG2; that is e0+16 for defaults. `BUSY` falls at that same edge.
- Each extra RECOV cycle spent waiting adds one cycle to latency.
- Measurement window: exactly one `CLK` period, from the `LAUNCH` rise to the stage-1 capture.
- A new `START` is accepted at the edge after `VALID`, i.e. back-to-back measurements are allowed.

## Structure
- Package `dlyc_tdc_pkg`: state enum, `RECOV_TIMEOUT`=8, count-width function.
- Sub-module `dlyc_therm_enc`: combinational NTAPS thermometer → count, plus bubble and saturation flags; instanced once on stage-2.
- The capture registers, FSM and accumulator live in the top.

## Test plan
- Bench drives `TAPS` = `LAUNCH` ? 16'h00FF : 0 with defaults; pulse `START` → `VALID` after 16 edges, `CODE`=8, `ERR`=0, `SAT`=0.
- Patterns 0x007F, 0x00FF, 0x00FF, 0x00FF on successive launches → sum 31, `CODE`=7.
- `TAPS`=0x0F3F while launched → bubble; `ERR`=1, `CODE`=6.
- `TAPS`=0xFFFF while launched → `SAT`=1, `CODE`=16.
- `TAPS` stuck at 0x0001 regardless of `LAUNCH` → RECOV timeout; `VALID` with `ERR`=1, `CODE`=0, `BUSY`=0.
- `RST` asserted during CAP2 of the second launch → `LAUNCH`=0 and `BUSY`=0 immediately, no `VALID`. A following `START` gives a clean `CODE`=8.
